// File: rtl/camera_control_pkg.sv
// camera_control_pkg: capture FSM states and frame-start marker shared by the packer and the frame uploader
package camera_control_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    FRAME_START,
    WAIT_LINE,
    CAPTURE_LINE,
    FRAME_END
  } cam_state_e;
  localparam logic [16:0] FRAME_START_MARKER = 17'h10000;
endpackage

// File: rtl/cam_input_sync.sv
// cam_input_sync: registers the camera pins once and detects vsync/href edges on the registered copies
module cam_input_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       href_rise_o,
  output logic       href_fall_o
);
  logic       vsync_q, vsync_prev_q, href_q, href_prev_q;
  logic [7:0] data_q;
  // pin sampling stage plus one delayed copy of each strobe for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      vsync_q      <= vsync_i;
      vsync_prev_q <= vsync_q;
      href_q       <= href_i;
      href_prev_q  <= href_q;
      data_q       <= data_i;
    end
  end
  assign data_o       = data_q;
  assign vsync_rise_o = vsync_q & ~vsync_prev_q;
  assign vsync_fall_o = ~vsync_q & vsync_prev_q;
  assign href_rise_o  = href_q & ~href_prev_q;
  assign href_fall_o  = ~href_q & href_prev_q;
endmodule

// File: rtl/camera_pixel_packer.sv
// camera_pixel_packer: packs RGB565 camera bytes into 17-bit FIFO words with a frame-start marker.
// Optional feature macro CAMERA_TEST_PATTERN_EN adds a test_mode input that substitutes a coordinate pattern.
module camera_pixel_packer
  import camera_control_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  cam_data,
  input  logic        queue_full,
`ifdef CAMERA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        frame_done,
  output logic        overflow
);
  localparam int PW = $clog2(FRAME_WIDTH + 1);
  localparam int LW = $clog2(FRAME_HEIGHT + 1);

  cam_state_e  state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic [7:0]  hi_q, hi_d, cam_byte;
  logic        phase_q, phase_d, wr_q, wr_d, done_q, done_d, ovf_q, ovf_d, mdrop_q, mdrop_d;
  logic [16:0] data_q, data_d;
  logic [15:0] pix_val;
  logic        v_rise, v_fall, h_rise, h_fall;

  cam_input_sync u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_i     (vsync),
    .href_i      (href),
    .data_i      (cam_data),
    .data_o      (cam_byte),
    .vsync_rise_o(v_rise),
    .vsync_fall_o(v_fall),
    .href_rise_o (h_rise),
    .href_fall_o (h_fall)
  );

`ifdef CAMERA_TEST_PATTERN_EN
  logic [7:0] y_lo;
  assign y_lo    = 8'(line_q);
  assign pix_val = test_mode ? (16'(pix_q) ^ {y_lo, 8'h00}) : {hi_q, cam_byte};
`else
  assign pix_val = {hi_q, cam_byte};
`endif

  // next-state and registered-output logic; a dropped marker sets overflow one cycle after the clear
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    hi_d    = hi_q;
    phase_d = phase_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | mdrop_q;
    mdrop_d = 1'b0;
    case (state_q)
      IDLE:       state_d = enable ? WAIT_VSYNC : IDLE;
      WAIT_VSYNC: state_d = v_fall ? FRAME_START : WAIT_VSYNC;
      FRAME_START: begin
        wr_d    = ~queue_full;
        data_d  = queue_full ? data_q : FRAME_START_MARKER;
        ovf_d   = 1'b0;
        mdrop_d = queue_full;
        pix_d   = '0;
        line_d  = '0;
        phase_d = 1'b0;
        state_d = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (v_rise) state_d = FRAME_END;
        else if (h_rise && line_q < LW'(FRAME_HEIGHT)) begin
          state_d = CAPTURE_LINE;
          pix_d   = '0;
          hi_d    = cam_byte;
          phase_d = 1'b1;
        end
      end
      CAPTURE_LINE: begin
        if (v_rise) state_d = FRAME_END;
        else if (h_fall) begin
          state_d = WAIT_LINE;
          phase_d = 1'b0;
          line_d  = line_q == LW'(FRAME_HEIGHT) ? line_q : line_q + LW'(1);
        end else if (!phase_q) begin
          hi_d    = cam_byte;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (pix_q < PW'(FRAME_WIDTH)) begin
            pix_d  = pix_q + PW'(1);
            wr_d   = ~queue_full;
            data_d = queue_full ? data_q : {1'b0, pix_val};
            ovf_d  = ovf_d | queue_full;
          end
        end
      end
      FRAME_END: begin
        done_d  = 1'b1;
        state_d = enable ? WAIT_VSYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset drops any partial pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      hi_q    <= 8'h00;
      phase_q <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      hi_q    <= hi_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      mdrop_q <= mdrop_d;
    end
  end

  assign queue_wr_en = wr_q;
  assign queue_data  = data_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_camera_pixel_packer.sv
// tb_camera_pixel_packer: randomized frames checked against a pixel-level reference model
module tb_camera_pixel_packer;
  localparam int W = 8;
  localparam int H = 4;
  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, vsync = 1'b1, href = 1'b0, queue_full = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        queue_wr_en, frame_done, overflow;
  logic [16:0] queue_data;
`ifdef CAMERA_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  camera_pixel_packer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .queue_full (queue_full),
`ifdef CAMERA_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .queue_wr_en(queue_wr_en),
    .queue_data (queue_data),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          cyc = 0, n_tests = 0, n_fail = 0, n_done = 0;
  logic [16:0] got_d[$], exp_d[$];
  int          got_c[$], exp_c[$];
  int          lens[$];
  bit          hold_full = 1'b0;
  logic [7:0]  dirb[4] = '{8'hF8, 8'h00, 8'h07, 8'hE0};

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: collect pushes with their cycle stamp and count frame_done cycles
  always @(negedge clk) begin
    if (queue_wr_en) begin
      got_d.push_back(queue_data);
      got_c.push_back(cyc);
    end
    if (frame_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one pin cycle; a full flag is held one extra cycle so it covers the push attempt
  task automatic drive(input logic v, input logic h, input logic [7:0] d, input logic f);
    step();
    vsync      = v;
    href       = h;
    cam_data   = d;
    queue_full = f | hold_full;
    hold_full  = f;
  endtask

  task automatic scoreboard(input string tag);
    repeat (4) step();
    check({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check({tag, "_data"}, 32'(got_d[i]), 32'(exp_d[i]));
      if (exp_c[i] >= 0) check({tag, "_lat"}, got_c[i], exp_c[i]);
    end
    got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  // one frame of lines from lens; the model predicts every push, its cycle, overflow and frame_done
  task automatic run_frame(input string tag, input int lf, input int pf, input bit mfull,
                           input bit en, input bit en_mid, input bit tm, input bit dir);
    bit ovf = mfull;
    int d0 = n_done;
    int y = 0;
    logic [7:0] hi = 8'h00, b;
    logic [15:0] px;
    bit full;
    enable = en;
`ifdef CAMERA_TEST_PATTERN_EN
    test_mode = tm;
`endif
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, mfull);
    if (en && !mfull) begin exp_d.push_back(17'h10000); exp_c.push_back(-1); end
    repeat (4) drive(1'b0, 1'b0, 8'h00, mfull);
    if (en) check({tag, "_ovf_start"}, 32'(overflow), 32'(mfull));
    if (en_mid) enable = 1'b0;
    for (int l = 0; l < lens.size(); l++) begin
      for (int k = 0; k < lens[l]; k++) begin
        b = dir ? dirb[k % 4] : 8'($urandom);
        full = (l == lf) && (k == 2 * pf + 1);
        drive(1'b0, 1'b1, b, full);
        if (k % 2 == 0) hi = b;
        else if (en && y < H && k / 2 < W) begin
          px = tm ? (16'(k / 2) ^ {8'(y), 8'h00}) : {hi, b};
          if (full) ovf = 1'b1;
          else begin exp_d.push_back({1'b0, px}); exp_c.push_back(cyc + 2); end
        end
      end
      if (lens[l] > 0 && y < H) y++;
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    repeat (6) drive(1'b1, 1'b0, 8'h00, 1'b0);
    check({tag, "_done"}, n_done - d0, 32'(en));
    if (en) check({tag, "_ovf_end"}, 32'(overflow), 32'(ovf));
    scoreboard(tag);
    enable = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (3) step();
    check("rst_wr", 32'(queue_wr_en), 0);
    check("rst_data", 32'(queue_data), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    lens = {4};             run_frame("dir",   -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    lens = {2 * W + 4, 3};  run_frame("wide",  -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lens = {2 * W, 2 * W};  run_frame("full",   0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lens = {2 * W, 2 * W, 2 * W, 2 * W, 2 * W};
                            run_frame("tall",  -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    lens = {2 * W};         run_frame("mfull", -1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    lens = {2 * W, 6};      run_frame("enmid", -1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lens = {2 * W};         run_frame("en0",   -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset in the middle of a line: nothing may be pushed until a new vsync fall
    d0 = n_done;
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    reset_n = 1'b0;
    got_d.delete(); got_c.delete();
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    check("midrst_wr", 32'(queue_wr_en), 0);
    check("midrst_data", 32'(queue_data), 0);
    check("midrst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    repeat (6) drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("midrst_pushes", got_d.size(), 0);
    check("midrst_done", n_done - d0, 0);
    got_d.delete(); got_c.delete();
`ifdef CAMERA_TEST_PATTERN_EN
    lens = {2 * W, 2 * W, 2 * W}; run_frame("tpat", -1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    for (int r = 0; r < 8; r++) begin
      lens.delete();
      repeat ($urandom_range(1, H + 1)) lens.push_back(int'($urandom_range(0, 2 * W + 5)));
      run_frame("rand", int'($urandom_range(0, H)), int'($urandom_range(0, W)),
                $urandom_range(0, 7) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
